// File: rtl/bus_port_bridge_if.sv
// CPU-side address/strobe signals and per-channel byte-stream handshakes of bus_port_bridge.
// The shared tristate data bus stays a plain inout port on the bridge itself.
interface bus_port_bridge_if #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned CHANNELS = 2
);
    logic [ADDR_W-1:0]          addr_bus;
    logic                       mem_out;
    logic                       mem_in;
    logic                       bus_drive;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic [CHANNELS-1:0]        in_valid;
    logic [CHANNELS-1:0]        in_ready;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic [CHANNELS-1:0]        out_valid;
    logic [CHANNELS-1:0]        out_ready;
    logic [CHANNELS-1:0]        irq;

    modport slave (
        input  addr_bus, mem_out, mem_in, in_data, in_valid, out_ready,
        output bus_drive, in_ready, out_data, out_valid, irq
    );

    modport master (
        output addr_bus, mem_out, mem_in, in_data, in_valid, out_ready,
        input  bus_drive, in_ready, out_data, out_valid, irq
    );
endinterface

// File: rtl/bus_port_bridge.sv
// Memory-mapped bridge: per-channel receive FIFOs and transmit holding registers
// exposed on the CPU tristate data bus, plus a status register and irq lines.
module bus_port_bridge #(
    parameter int unsigned      DATA_W    = 8,
    parameter int unsigned      ADDR_W    = 16,
    parameter int unsigned      CHANNELS  = 2,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00
) (
    input  logic               clk,
    input  logic               rst,
    bus_port_bridge_if.slave   bus,
    inout  wire [DATA_W-1:0]   data_bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [ADDR_W-1:0] offset_c;
    logic              data_hit_c, stat_hit_c, rd_hit_c, wr_hit_c;
    logic              pop_evt_c, wr_rise_c;
    logic [IW-1:0]     ch_c;
    logic [DATA_W-1:0] rd_data_c;

    logic              prev_rd_hit_q, prev_rd_hit_d;
    logic              prev_wr_hit_q, prev_wr_hit_d;
    logic              rd_is_data_q,  rd_is_data_d;
    logic [IW-1:0]     rd_ch_q,       rd_ch_d;
    logic [DATA_W-1:0] mem_q       [CHANNELS][DEPTH];
    logic [DATA_W-1:0] mem_d       [CHANNELS][DEPTH];
    logic [PW-1:0]     wr_ptr_q    [CHANNELS];
    logic [PW-1:0]     wr_ptr_d    [CHANNELS];
    logic [PW-1:0]     rd_ptr_q    [CHANNELS];
    logic [PW-1:0]     rd_ptr_d    [CHANNELS];
    logic [CW-1:0]     count_q     [CHANNELS];
    logic [CW-1:0]     count_d     [CHANNELS];
    logic [DATA_W-1:0] out_data_q  [CHANNELS];
    logic [DATA_W-1:0] out_data_d  [CHANNELS];
    logic [CHANNELS-1:0] out_valid_q, out_valid_d;

    // Address decode; addresses below BASE_ADDR wrap to large offsets and miss.
    assign offset_c   = bus.addr_bus - BASE_ADDR;
    assign data_hit_c = offset_c < ADDR_W'(CHANNELS);
    assign stat_hit_c = offset_c == ADDR_W'(CHANNELS);
    assign ch_c       = IW'(offset_c);
    assign rd_hit_c   = bus.mem_out & ~bus.mem_in & (data_hit_c | stat_hit_c);
    assign wr_hit_c   = bus.mem_in & ~bus.mem_out & (data_hit_c | stat_hit_c);
    assign pop_evt_c  = prev_rd_hit_q & ~rd_hit_c & rd_is_data_q;
    assign wr_rise_c  = wr_hit_c & ~prev_wr_hit_q & data_hit_c;

    always_comb begin
        rd_data_c = '0;
        if (stat_hit_c) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                rd_data_c[i]          = count_q[i] != '0;
                rd_data_c[CHANNELS+i] = out_valid_q[i];
            end
        end else if (count_q[ch_c] != '0) begin
            rd_data_c = mem_q[ch_c][rd_ptr_q[ch_c]];
        end
    end

    assign data_bus      = rd_hit_c ? rd_data_c : 'z;
    assign bus.bus_drive = rd_hit_c;
    assign bus.out_valid = out_valid_q;

    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            bus.in_ready[i]                   = count_q[i] != CW'(DEPTH);
            bus.irq[i]                        = count_q[i] != '0;
            bus.out_data[i*DATA_W +: DATA_W]  = out_data_q[i];
        end
    end

    always_comb begin
        logic push, pop, drain, cap;
        prev_rd_hit_d = rd_hit_c;
        prev_wr_hit_d = wr_hit_c;
        rd_is_data_d  = rd_is_data_q;
        rd_ch_d       = rd_ch_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        if (rd_hit_c) begin
            rd_is_data_d = data_hit_c;
            rd_ch_d      = ch_c;
        end
        for (int i = 0; i < int'(CHANNELS); i++) begin
            push = bus.in_valid[i] & (count_q[i] != CW'(DEPTH));
            pop  = pop_evt_c & (rd_ch_q == IW'(i)) & (count_q[i] != '0);
            if (push) begin
                mem_d[i][wr_ptr_q[i]] = bus.in_data[i*DATA_W +: DATA_W];
                wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
            end
            if (pop) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
            case ({push, pop})
                2'b10:   count_d[i] = count_q[i] + CW'(1);
                2'b01:   count_d[i] = count_q[i] - CW'(1);
                default: count_d[i] = count_q[i];
            endcase
            // A drain on the same edge frees the holding register for the new byte.
            drain = out_valid_q[i] & bus.out_ready[i];
            cap   = wr_rise_c & (ch_c == IW'(i)) & (~out_valid_q[i] | bus.out_ready[i]);
            out_valid_d[i] = (out_valid_q[i] & ~drain) | cap;
            if (cap) out_data_d[i] = data_bus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_rd_hit_q <= 1'b0;
            prev_wr_hit_q <= 1'b0;
            rd_is_data_q  <= 1'b0;
            rd_ch_q       <= '0;
            out_valid_q   <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                count_q[i]    <= '0;
                out_data_q[i] <= '0;
                for (int j = 0; j < int'(DEPTH); j++) mem_q[i][j] <= '0;
            end
        end else begin
            prev_rd_hit_q <= prev_rd_hit_d;
            prev_wr_hit_q <= prev_wr_hit_d;
            rd_is_data_q  <= rd_is_data_d;
            rd_ch_q       <= rd_ch_d;
            out_valid_q   <= out_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_data_q    <= out_data_d;
            mem_q         <= mem_d;
        end
    end
endmodule

// File: tb/tb_bus_port_bridge.sv
// Directed bench for bus_port_bridge: FIFO reads, overflow, wrap, transmit capture,
// status decode, same-edge push/pop and capture/drain, and asynchronous reset.
module tb_bus_port_bridge;
    logic       clk = 1'b0;
    logic       rst;
    logic       tb_drv;
    logic [7:0] tb_val;
    wire  [7:0] data_bus;
    int         checks = 0;
    int         errors = 0;

    bus_port_bridge_if #(.DATA_W(8), .ADDR_W(16), .CHANNELS(2)) bif ();

    bus_port_bridge #(
        .DATA_W(8), .ADDR_W(16), .CHANNELS(2), .DEPTH(4), .BASE_ADDR(16'hFF00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif.slave),
        .data_bus (data_bus)
    );

    assign data_bus = tb_drv ? tb_val : 'z;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read strobe held for n edges, then released for the pop edge.
    task automatic rd(input logic [15:0] a, input int n, input logic [7:0] exp, input string tag);
        bif.addr_bus = a;
        bif.mem_out  = 1'b1;
        #1;
        chk({tag, "_drive"}, 32'(bif.bus_drive), 32'd1);
        chk(tag, 32'(data_bus), 32'(exp));
        repeat (n) tick();
        bif.mem_out = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] v, input int n);
        bif.addr_bus = a;
        tb_val       = v;
        tb_drv       = 1'b1;
        bif.mem_in   = 1'b1;
        repeat (n) tick();
        bif.mem_in = 1'b0;
        tb_drv     = 1'b0;
        tick();
    endtask

    task automatic push(input int ch, input logic [7:0] v);
        bif.in_data[ch*8 +: 8] = v;
        bif.in_valid[ch]       = 1'b1;
        tick();
        bif.in_valid[ch] = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;
        rst           = 1'b0;
        tb_drv        = 1'b0;
        tb_val        = '0;
        bif.addr_bus  = '0;
        bif.mem_out   = 1'b0;
        bif.mem_in    = 1'b0;
        bif.in_data   = '0;
        bif.in_valid  = '0;
        bif.out_ready = '0;
        #2;
        chk("rst_in_ready", 32'(bif.in_ready), 32'h3);
        chk("rst_irq", 32'(bif.irq), 32'h0);
        chk("rst_drive", 32'(bif.bus_drive), 32'h0);
        chk("rst_out_valid", 32'(bif.out_valid), 32'h0);
        chk("rst_out_data", 32'(bif.out_data), 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Channel 0: two bytes, two reads, then an empty read.
        push(0, 8'h11);
        push(0, 8'h22);
        chk("irq_after_push", 32'(bif.irq), 32'h1);
        rd(16'hFF00, 3, 8'h11, "rd0_first");
        chk("irq_still_set", 32'(bif.irq), 32'h1);
        rd(16'hFF00, 3, 8'h22, "rd0_second");
        chk("irq_cleared", 32'(bif.irq), 32'h0);
        rd(16'hFF00, 3, 8'h00, "rd0_empty");
        chk("irq_empty_read", 32'(bif.irq), 32'h0);

        // Channel 1: fill, overflow attempt, pop, wrap-around.
        for (int k = 0; k < 4; k++) push(1, 8'hA0 + 8'(k));
        chk("ch1_full", 32'(bif.in_ready), 32'h1);
        bif.in_data[15:8] = 8'hA4;
        bif.in_valid[1]   = 1'b1;
        tick();
        tick();
        bif.in_valid[1] = 1'b0;
        chk("ch1_still_full", 32'(bif.in_ready), 32'h1);
        rd(16'hFF01, 3, 8'hA0, "rd1_head");
        chk("ch1_ready_back", 32'(bif.in_ready), 32'h3);
        for (int k = 0; k < 10; k++) begin
            push(1, 8'hB0 + 8'(k));
            exp_b = (k < 3) ? 8'hA1 + 8'(k) : 8'hB0 + 8'(k - 3);
            rd(16'hFF01, 1, exp_b, "rd1_wrap");
        end
        rd(16'hFF01, 2, 8'hB7, "rd1_tail7");
        rd(16'hFF01, 2, 8'hB8, "rd1_tail8");
        rd(16'hFF01, 2, 8'hB9, "rd1_tail9");
        chk("ch1_drained", 32'(bif.irq), 32'h0);

        // Transmit capture, drop while full.
        wr(16'hFF01, 8'h5A, 4);
        chk("tx_valid", 32'(bif.out_valid), 32'h2);
        chk("tx_data", 32'(bif.out_data[15:8]), 32'h5A);
        wr(16'hFF01, 8'h77, 2);
        chk("tx_drop", 32'(bif.out_data[15:8]), 32'h5A);

        // Status register and misses.
        push(0, 8'h33);
        rd(16'hFF02, 2, 8'h09, "status");
        bif.addr_bus = 16'hFF03;
        bif.mem_out  = 1'b1;
        #1;
        chk("miss_ff03", 32'(bif.bus_drive), 32'h0);
        tick();
        bif.addr_bus = 16'hFF00;
        bif.mem_in   = 1'b1;
        tb_drv       = 1'b1;
        tb_val       = 8'hEE;
        #1;
        chk("both_strobes", 32'(bif.bus_drive), 32'h0);
        tick();
        bif.mem_out = 1'b0;
        bif.mem_in  = 1'b0;
        tb_drv      = 1'b0;
        tick();
        chk("both_no_capture", 32'(bif.out_valid), 32'h2);
        chk("both_no_pop", 32'(bif.irq), 32'h1);
        bif.out_ready = 2'b10;
        tick();
        bif.out_ready = 2'b00;
        chk("tx_drained", 32'(bif.out_valid), 32'h0);

        // Same-edge push and pop at count 2.
        push(0, 8'h44);
        bif.addr_bus = 16'hFF00;
        bif.mem_out  = 1'b1;
        #1;
        chk("pp_head", 32'(data_bus), 32'h33);
        tick();
        tick();
        bif.mem_out    = 1'b0;
        bif.in_data[7:0] = 8'h55;
        bif.in_valid[0]  = 1'b1;
        tick();
        bif.in_valid[0] = 1'b0;
        rd(16'hFF00, 1, 8'h44, "pp_second");
        rd(16'hFF00, 1, 8'h55, "pp_third");
        chk("pp_count2", 32'(bif.irq), 32'h0);

        // Same-edge drain and capture.
        wr(16'hFF00, 8'h66, 2);
        chk("cd_first", 32'(bif.out_data[7:0]), 32'h66);
        bif.addr_bus  = 16'hFF00;
        tb_val        = 8'h67;
        tb_drv        = 1'b1;
        bif.mem_in    = 1'b1;
        bif.out_ready = 2'b01;
        tick();
        bif.out_ready = 2'b00;
        bif.mem_in    = 1'b0;
        tb_drv        = 1'b0;
        tick();
        chk("cd_valid", 32'(bif.out_valid), 32'h1);
        chk("cd_data", 32'(bif.out_data[7:0]), 32'h67);

        // Asynchronous reset in the middle of a read.
        push(0, 8'hC0);
        push(0, 8'hC1);
        push(0, 8'hC2);
        bif.addr_bus = 16'hFF00;
        bif.mem_out  = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b0;
        bif.mem_out = 1'b0;
        #1;
        chk("ar_irq", 32'(bif.irq), 32'h0);
        chk("ar_in_ready", 32'(bif.in_ready), 32'h3);
        chk("ar_drive", 32'(bif.bus_drive), 32'h0);
        chk("ar_out_valid", 32'(bif.out_valid), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rd(16'hFF00, 2, 8'h00, "ar_empty_read");
        chk("ar_irq_after", 32'(bif.irq), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_port_bridge.md
# bus_port_bridge

Parametrised memory-mapped bridge between the CPU's shared tristate data bus and CHANNELS external byte-stream channels. Each channel has a DEPTH-entry receive FIFO (external producer to CPU reads) and a one-entry transmit holding register (CPU writes to external consumer). The block decodes the CPU address bus and memory strobes, drives the data bus only when addressed, and exposes a status register and per-channel interrupt requests. It sits beside the CPU in the top-level or adapter, on the same `data_bus` net as memory.

## Interface
- DATA_W, 8, data bus and channel width
- ADDR_W, 16, CPU address bus width
- CHANNELS, 2, channel count; 1 to DATA_W/2
- DEPTH, 4, receive FIFO depth per channel; power of two, at least 2
- BASE_ADDR, 16'hFF00, first mapped address
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- addr_bus  in  ADDR_W  CPU address
- mem_out  in  1  CPU read strobe; the addressed device drives `data_bus`
- mem_in  in  1  CPU write strobe; the addressed device captures `data_bus`
- data_bus  inout  DATA_W  shared CPU data bus
- bus_drive  out  1  high while the block drives `data_bus`
- in_data  in  CHANNELS*DATA_W  producer bytes; channel i is bits [i*DATA_W +: DATA_W]
- in_valid / in_ready  in / out  CHANNELS  receive handshake, per channel
- out_data  out  CHANNELS*DATA_W  transmit holding registers
- out_valid / out_ready  out / in  CHANNELS  transmit handshake, per channel
- irq  out  CHANNELS  bit i high while receive FIFO i is non-empty

## Operation
- Address map: BASE_ADDR+i is data channel i, for i < CHANNELS. BASE_ADDR+CHANNELS is the status register. All other addresses miss.
- rd_hit = mem_out & !mem_in & address hit. wr_hit = mem_in & !mem_out & address hit. If both strobes are high, neither hit is produced.
- Bus drive:
  - `data_bus` is driven only while rd_hit is high. Otherwise it is high-Z and bus_drive = 0.
  - Drive is combinational from registered state.
  - Data channel read: drive the FIFO i head, or 0x00 if FIFO i is empty.
  - Status read: bits [CHANNELS-1:0] = receive non-empty flags. Bits [2*CHANNELS-1:CHANNELS] = out_valid flags. Remaining bits are 0.
- Read pop:
  - Register prev_rd_hit and the channel index of the current read.
  - On the edge where prev_rd_hit = 1 and rd_hit = 0 (strobe falling) for a data address, pop one entry if the FIFO is non-empty.
  - A read while empty pops nothing.
  - A status read pops nothing.
  - Exactly one pop per strobe, regardless of strobe length.
- Write capture:
  - On the first edge where wr_hit = 1 and prev_wr_hit = 0, for data channel i:
    - If out_valid[i] = 0, load the bus byte into out_data i and set out_valid[i].
    - If out_valid[i] = 1, drop the byte and leave the register unchanged.
  - Writes to the status address are ignored.
  - Exactly one capture per strobe.
- Receive push: in_ready[i] = !full[i]. On in_valid & in_ready, the byte is written at the tail.
- Transmit drain: on out_valid & out_ready, out_valid clears.
- FIFO: DEPTH-entry circular buffer.
  - Read/write pointers of log2(DEPTH) bits wrap modulo DEPTH.
  - Occupancy counter 0..DEPTH. full = (count == DEPTH), empty = (count == 0).

## Timing
- Reset (rst = 0, asynchronous), all outputs and state:
  - FIFOs empty, pointers 0, count 0
  - out_valid = 0, out_data = 0
  - prev_rd_hit = 0, prev_wr_hit = 0
  - in_ready = all 1, irq = 0, bus_drive = 0, `data_bus` high-Z
- Reset asserted mid-strobe: no pop or capture occurs. After release, a still-active strobe is treated as newly rising (capture happens for writes).
- Receive latency: a byte pushed at edge N is visible on the bus, and irq rises, after edge N.
- Simultaneous push and pop on the same FIFO: both happen and count is unchanged. When full, no push is possible in that cycle (in_ready is low).
- Simultaneous capture and drain on channel i: the drain completes and the capture loads. out_valid stays 1 and out_data takes the new byte.
- Address change while mem_out is held: the pop target is the channel registered on the last rd_hit cycle.
- A rd_hit moving directly from channel a to channel b without a gap counts as no falling edge. The bus master must deassert mem_out between reads.

## Test plan
- Reset, then push 0x11, 0x22 on channel 0. Two 3-cycle reads at 0xFF00 -> bus shows 0x11 then 0x22. irq[0] falls after the second strobe ends. A third read -> 0x00 with no pop.
- Push DEPTH = 4 bytes 0xA0..0xA3 on channel 1 -> in_ready[1] = 0 after the 4th. A 5th byte with in_valid held is not accepted. One read -> 0xA0, and in_ready[1] returns to 1 the cycle after the strobe falls. Wrap-around order is preserved over 10 further push/pop pairs.
- CPU writes 0x5A to 0xFF01 with a 4-cycle strobe and out_ready = 0 -> out_data 1 = 0x5A, out_valid[1] = 1 (single capture). A second write of 0x77 is dropped. out_ready = 1 -> out_valid clears.
- Status read at 0xFF02 with channel 0 non-empty and channel 1 transmit full -> 0x09. Read at 0xFF03 or with mem_in and mem_out both high -> bus_drive = 0 and the bus stays high-Z.
- Push and pop on channel 0 in the same cycle at count 2 -> count stays 2. Drain and capture on the same edge -> out_valid stays 1 with the new byte.
- rst pulsed low mid-read with FIFO count 3 -> FIFO empty, no drive, irq = 0 asynchronously, before the next clock edge.
